// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: fetch-stage bus bundle (ROM port, redirect input, decode handshake)
//   master (fetch unit): drives rom_addr, if_valid, if_pc, if_inst, if_fault
//                        samples rom_data, redirect_valid, redirect_pc, if_ready
//   slave (environment): the mirror image of master
interface inst_fetch_unit_if #(parameter int ROM_AW = 11);
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_pc;
    logic [31:0]       if_inst;
    logic              if_fault;
    modport master (
        output rom_addr, if_valid, if_pc, if_inst, if_fault,
        input  rom_data, redirect_valid, redirect_pc, if_ready
    );
    modport slave (
        input  rom_addr, if_valid, if_pc, if_inst, if_fault,
        output rom_data, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch PC, ROM addressing, small instruction FIFO to decode, redirect/flush, fault flagging
//   clk, rst : clock, asynchronous active-high reset
//   bus      : inst_fetch_unit_if.master (ROM word port, redirect, valid/ready head entry to decode)
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] ROM_BASE   = 32'h0000_0000,
    parameter int          ROM_AW     = 11,
    parameter int          FIFO_DEPTH = 2
) (
    input logic               clk,
    input logic               rst,
    inst_fetch_unit_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
    typedef enum logic {FETCH, HALT} state_t;
    state_t        state, state_next;
    logic [31:0]   fetch_pc;
    logic [29:0]   off_word;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [31:0]   mem_pc   [FIFO_DEPTH];
    logic [31:0]   mem_inst [FIFO_DEPTH];
    logic          mem_fault[FIFO_DEPTH];
    logic          fault, push, pop;
    // word offset from ROM base; anything above the ROM word range is out of range
    assign off_word     = 30'((fetch_pc - ROM_BASE) >> 2);
    assign fault        = |fetch_pc[1:0] || |off_word[29:ROM_AW];
    assign bus.rom_addr = off_word[ROM_AW-1:0];
    // redirect wins over both ends of the FIFO
    assign pop  = bus.if_valid && bus.if_ready && !bus.redirect_valid;
    assign push = state == FETCH && !bus.redirect_valid && (count < FULL || pop);
    assign bus.if_valid = count != '0;
    assign bus.if_pc    = mem_pc[rd_ptr];
    assign bus.if_inst  = mem_inst[rd_ptr];
    assign bus.if_fault = mem_fault[rd_ptr];
    always_comb state_next = bus.redirect_valid ? FETCH : (push && fault) ? HALT : state;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= FETCH;
        else     state <= state_next;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_inst[i]  <= '0;
                mem_fault[i] <= 1'b0;
            end
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            // full + pop + push writes the slot being read this cycle; the read sees the old word
            if (push) begin
                mem_pc[wr_ptr]    <= fetch_pc;
                mem_inst[wr_ptr]  <= fault ? 32'h0000_0013 : bus.rom_data;
                mem_fault[wr_ptr] <= fault;
                wr_ptr            <= wr_ptr + 1'b1;
                fetch_pc          <= fetch_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule
